seg_scan_driver: RTL

Time-multiplexed scan driver for a 4-digit common-anode seven-segment display. It consumes the four active-low segment patterns produced by the binary-to-decimal converter stage and drives the shared cathode bus and the per-digit anode enables. It snapshots all four digits once per frame so the display cannot tear, inserts an anti-ghosting dead time at the start of every digit slot, and optionally blanks leading zeros.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/scan_prescaler.sv | 36 +++
 rtl/seg_scan_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 4;
    localparam int unsigned DIG_N  = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0000001;
    localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

    typedef logic [1:0] slot_t;

    // One frame's worth of display content, captured at frame start.
    typedef struct packed {
        logic [DIG_N-1:0][SEG_W-1:0] dig;
        logic                        blank_lz;
        logic [DIG_N-1:0]            dp_mask;
    } snap_t;

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and wraps.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (holds the count at 0)
//   o_pre      : current count (registered)
//   o_tc_c     : combinational terminal-count flag (count == REFRESH_DIV-1)
module scan_prescaler #(
    parameter  int unsigned REFRESH_DIV = 100000,
    localparam int unsigned PRE_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    output logic [PRE_W-1:0] o_pre,
    output logic             o_tc_c
);

    logic [PRE_W-1:0] r_pre;

    assign o_tc_c = (r_pre == PRE_W'(REFRESH_DIV - 1));
    assign o_pre  = r_pre;

    // Free-running slot prescaler with wrap at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (i_clr) begin
            r_pre <= '0;
        end else if (o_tc_c) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Snapshots the digits once per frame, inserts a dead time at the start of
// each digit slot and optionally blanks leading zeros.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   enable              : scan enable; low darkens the display and restarts the scan
//   digit0..digit3      : active-low segment patterns, digit0 least significant
//   blank_lz            : leading-zero blanking enable
//   dp_mask             : bit i lights the decimal point of digit i
//   an                  : active-low anode enables (registered)
//   seg, dp             : active-low cathodes and decimal point (registered)
//   frame_tick          : one-cycle pulse after every snapshot (registered)
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [SEG_W-1:0] digit0,
    input  logic [SEG_W-1:0] digit1,
    input  logic [SEG_W-1:0] digit2,
    input  logic [SEG_W-1:0] digit3,
    input  logic             blank_lz,
    input  logic [DIG_N-1:0] dp_mask,
    output logic [AN_W-1:0]  an,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic             frame_tick
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    logic [PRE_W-1:0] w_pre;
    logic             w_tc;
    logic             w_clr;
    logic             w_frame_start;
    logic             w_blank3;
    logic             w_blank2;
    logic             w_blank1;
    logic [DIG_N-1:0] w_blank;
    logic [AN_W-1:0]  w_an;
    logic [SEG_W-1:0] w_seg;
    logic             w_dp;

    slot_t            r_slot;
    snap_t            r_snap;

    assign w_clr = ~enable;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_pre  (w_pre),
        .o_tc_c (w_tc)
    );

    assign w_frame_start = enable && (r_slot == slot_t'(0)) && (w_pre == '0);

    // Slot counter: advances when the prescaler wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= slot_t'(0);
        end else if (!enable) begin
            r_slot <= slot_t'(0);
        end else if (w_tc) begin
            r_slot <= r_slot + slot_t'(1);
        end
    end

    // Frame snapshot: the only source for decode, so mid-frame input changes cannot tear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap.dig      <= {DIG_N{SEG_BLANK}};
            r_snap.blank_lz <= 1'b0;
            r_snap.dp_mask  <= '0;
        end else if (w_frame_start) begin
            r_snap.dig      <= {digit3, digit2, digit1, digit0};
            r_snap.blank_lz <= blank_lz;
            r_snap.dp_mask  <= dp_mask;
        end
    end

    // Leading-zero chain: a digit blanks only if every more significant digit blanked too.
    assign w_blank3 = r_snap.blank_lz && (r_snap.dig[3] == SEG_ZERO);
    assign w_blank2 = w_blank3 && (r_snap.dig[2] == SEG_ZERO);
    assign w_blank1 = w_blank2 && (r_snap.dig[1] == SEG_ZERO);
    assign w_blank  = {w_blank3, w_blank2, w_blank1, 1'b0};

    // Decode of the current slot; dead time keeps every anode off.
    always_comb begin
        w_an  = AN_OFF;
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (w_pre >= PRE_W'(BLANK_CYCLES)) begin
            w_an = ~(AN_W'(1) << r_slot);
            if (w_blank[r_slot]) begin
                w_seg = SEG_BLANK;
                w_dp  = 1'b1;
            end else begin
                w_seg = r_snap.dig[r_slot];
                w_dp  = ~r_snap.dp_mask[r_slot];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= w_an;
            seg        <= w_seg;
            dp         <= w_dp;
            frame_tick <= w_frame_start;
        end
    end

endmodule
